// File: rtl/score_display_ctrl.sv
// score_display_ctrl: four-digit BCD score counter with a frame-synchronous
// shadow-pattern walk and a registered pixel lookup that feeds a
// seven-segment renderer.
// Optional feature macro: SCORE_LZ_BLANK_EN (blank leading zero digits 3..1).
module score_display_ctrl #(
  parameter int ORIGIN_X    = 560,
  parameter int ORIGIN_Y    = 16,
  parameter int DIGIT_PITCH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_start,
  input  logic        score_inc,
  input  logic        score_clr,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  output logic [0:6]  seg_pattern,
  output logic [9:0]  seg_x,
  output logic [9:0]  seg_y,
  output logic        in_digit,
  output logic [15:0] score_bcd,
  output logic        overflow
);

  localparam logic [9:0] OX = 10'(ORIGIN_X);
  localparam logic [9:0] OY = 10'(ORIGIN_Y);

  typedef enum logic {IDLE, WALK} state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  walk_cnt;    // cell being loaded; cell c shows BCD digit 3-c
  logic [15:0] staged;      // score snapshot taken at frame_start
  logic [0:6]  shadow [4];  // displayed pattern per cell, cell 0 leftmost
  logic [3:0]  walk_digit;
  logic        walk_blank;
  logic [0:6]  walk_pat;
  logic        hit;
  logic [0:6]  hit_pat;
  logic [9:0]  hit_x;

  // Seven-segment encoding; index 0 of the result is the first character.
  function automatic logic [0:6] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Decimal +1 with carry ripple across the four nibbles.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Score counter: clear wins over increment, saturates at 9999.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_bcd <= 16'h0000;
      overflow  <= 1'b0;
    end else if (score_clr) begin
      score_bcd <= 16'h0000;
      overflow  <= 1'b0;
    end else if (score_inc) begin
      if (score_bcd == 16'h9999) overflow  <= 1'b1;
      else                       score_bcd <= bcd_inc(score_bcd);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state: start a walk on frame_start, leave after the fourth load.
  // NOTE: assign every comb output a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = WALK;
      WALK:    if (walk_cnt == 2'd3) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Pattern for the cell being loaded, with optional leading-zero blanking.
  always_comb begin
    walk_digit = staged[15:12];
    walk_blank = 1'b0;
    case (walk_cnt)
      2'd0: walk_digit = staged[15:12];
      2'd1: walk_digit = staged[11:8];
      2'd2: walk_digit = staged[7:4];
      2'd3: walk_digit = staged[3:0];
      default: walk_digit = staged[15:12];
    endcase
`ifdef SCORE_LZ_BLANK_EN
    case (walk_cnt)
      2'd0:    walk_blank = (staged[15:12] == 4'd0);
      2'd1:    walk_blank = (staged[15:8]  == 8'd0);
      2'd2:    walk_blank = (staged[15:4]  == 12'd0);
      default: walk_blank = 1'b0;
    endcase
`else
    walk_blank = 1'b0;
`endif
    walk_pat = walk_blank ? 7'b0000000 : seg_encode(walk_digit);
  end

  // Snapshot on frame_start in IDLE, then load one shadow cell per WALK cycle.
  // NOTE: the shadow store is four flops, not a RAM, so it takes the async reset directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      walk_cnt <= 2'd0;
      staged   <= 16'h0000;
      for (int c = 0; c < 4; c++) shadow[c] <= 7'b0000000;
    end else begin
      if (state == IDLE && frame_start) begin
        staged   <= score_bcd;
        walk_cnt <= 2'd0;
      end
      if (state == WALK) begin
        shadow[walk_cnt] <= walk_pat;
        walk_cnt         <= walk_cnt + 2'd1;
      end
    end
  end

  // Pixel lookup: find which cell, if any, contains (x, y).
  always_comb begin
    logic [9:0] left;
    hit     = 1'b0;
    hit_pat = 7'b0000000;
    hit_x   = OX;
    left    = OX;
    for (int c = 0; c < 4; c++) begin
      left = 10'(ORIGIN_X + c * DIGIT_PITCH);
      if (x >= left && x <= left + 10'd9 && y >= OY && y <= OY + 10'd19) begin
        hit     = 1'b1;
        hit_pat = shadow[c];
        hit_x   = left;
      end
    end
  end

  // Registered renderer outputs, one cycle behind x/y.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_pattern <= 7'b0000000;
      seg_x       <= OX;
      seg_y       <= OY;
      in_digit    <= 1'b0;
    end else begin
      seg_pattern <= hit_pat;
      seg_x       <= hit_x;
      seg_y       <= OY;
      in_digit    <= hit;
    end
  end

endmodule
